// File: rtl/sum_stim_checker.sv
// Stimulus generator and checker for an external adder: drives N_VEC operand pairs,
// compares the returned sums through a LAT+1 deep expected-value delay line and reports a verdict.
module sum_stim_checker #(
  parameter int W     = 8,
  parameter int LAT   = 1,
  parameter int N_VEC = 6
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         start,
  input  logic [W-1:0] seed_a,
  input  logic [W-1:0] seed_b,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_cnt,
  output logic [7:0]   first_err_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]            vec_idx;
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][W-1:0]   exp_pipe;
  logic [LAT:0][7:0]     idx_pipe;

  logic         accept, last_drive, cmp_en, mismatch, last_cmp;
  logic [W-1:0] a_nxt, b_nxt;
  logic [7:0]   err_nxt;

  assign accept     = (state == IDLE) && start;
  assign last_drive = (state == DRIVE) && (vec_idx == 8'(N_VEC - 1));
  assign a_nxt      = a + W'(1);
  assign b_nxt      = b + W'(2);

  // The oldest slot lines up with the adder output LAT+1 edges after its vector was driven.
  assign cmp_en   = vld_pipe[LAT];
  assign mismatch = cmp_en && (c !== exp_pipe[LAT]);
  assign last_cmp = cmp_en && (idx_pipe[LAT] == 8'(N_VEC - 1));
  assign err_nxt  = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  assign busy = (state == DRIVE) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = DRIVE;
      DRIVE:   if (last_drive) state_nxt = DRAIN;
      DRAIN:   if (last_cmp)   state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      a             <= '0;
      b             <= '0;
      vec_idx       <= '0;
      vld_pipe      <= '0;
      exp_pipe      <= '0;
      idx_pipe      <= '0;
      err_cnt       <= '0;
      first_err_idx <= 8'hFF;
      pass          <= 1'b0;
    end else begin
      vld_pipe[LAT:1] <= vld_pipe[LAT-1:0];
      exp_pipe[LAT:1] <= exp_pipe[LAT-1:0];
      idx_pipe[LAT:1] <= idx_pipe[LAT-1:0];
      vld_pipe[0]     <= 1'b0;

      if (accept) begin
        a             <= seed_a;
        b             <= seed_b;
        vec_idx       <= '0;
        vld_pipe[0]   <= 1'b1;
        exp_pipe[0]   <= seed_a + seed_b;
        idx_pipe[0]   <= '0;
        err_cnt       <= '0;
        first_err_idx <= 8'hFF;
        pass          <= 1'b0;
      end else begin
        if ((state == DRIVE) && !last_drive) begin
          a           <= a_nxt;
          b           <= b_nxt;
          vec_idx     <= vec_idx + 8'd1;
          vld_pipe[0] <= 1'b1;
          exp_pipe[0] <= a_nxt + b_nxt;
          idx_pipe[0] <= vec_idx + 8'd1;
        end else begin
          a <= '0;
          b <= '0;
        end

        err_cnt <= err_nxt;
        if (mismatch && (first_err_idx == 8'hFF)) first_err_idx <= idx_pipe[LAT];
        if (last_cmp) pass <= (err_nxt == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_sum_stim_checker.sv
// Scoreboard bench: stimulus pushes expected vectors and run verdicts, a negedge monitor
// pops and compares them; a behavioural adder with fault modes sits on a/b/c.
module tb_sum_stim_checker;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         areset, start;
  logic [W-1:0] seed_a, seed_b, a, b, c;
  logic         busy, done, pass;
  logic [7:0]   err_cnt, first_err_idx;

  int           fault = 0;
  logic [W-1:0] s1, s2;
  int           cyc = 0;
  int           n_chk = 0, n_pass = 0;

  typedef struct { int cyc; logic [7:0] a; logic [7:0] b; } vec_t;
  typedef struct { int cyc; logic p; logic [7:0] e; logic [7:0] f; } res_t;
  vec_t vec_q[$];
  res_t res_q[$];

  sum_stim_checker #(.W(W), .LAT(1), .N_VEC(6)) dut (
    .clk(clk), .areset(areset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test: 1-cycle registered, +1 on operand pair (5,9), or 2-cycle latency.
  always @(posedge clk) begin
    s1 <= a + b + ((fault == 1 && a == 8'd5 && b == 8'd9) ? 8'd1 : 8'd0);
    s2 <= s1;
  end
  assign c = (fault == 2) ? s2 : s1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_run(input int t0, input logic [7:0] sa, input logic [7:0] sb,
                          input logic p, input logic [7:0] e, input logic [7:0] f, input int nv);
    for (int k = 0; k < nv; k++)
      vec_q.push_back('{t0 + k, 8'(sa + 8'(k)), 8'(sb + 8'(2 * k))});
    if (nv == 6) begin
      vec_q.push_back('{t0 + 6, 8'd0, 8'd0});
      res_q.push_back('{t0 + 7, p, e, f});
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (res_q.size() == 0 && vec_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", res_q.size() + vec_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_run(input logic [7:0] sa, input logic [7:0] sb,
                        input logic p, input logic [7:0] e, input logic [7:0] f);
    seed_a = sa; seed_b = sb; start = 1'b1;
    push_run(cyc + 1, sa, sb, p, e, f, 6);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  always @(negedge clk) begin
    vec_t v;
    res_t r;
    if (vec_q.size() > 0 && vec_q[0].cyc <= cyc) begin
      v = vec_q.pop_front();
      chk("vec_cycle", cyc, v.cyc);
      chk("a", a, v.a);
      chk("b", b, v.b);
      chk("busy_in_run", busy, 1);
    end
    if (done) begin
      if (res_q.size() == 0) chk("done_unexpected", done, 0);
      else begin
        r = res_q.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("pass", pass, r.p);
        chk("err_cnt", err_cnt, r.e);
        chk("first_err_idx", first_err_idx, r.f);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    int t0;
    areset = 1'b1; start = 1'b0; seed_a = '0; seed_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err_idx, 8'hFF);
    areset = 1'b0;
    repeat (2) @(negedge clk);

    do_run(8'd2, 8'd3, 1'b1, 8'd0, 8'hFF);
    chk("pass_holds", pass, 1);
    do_run(8'hFE, 8'h01, 1'b1, 8'd0, 8'hFF);

    fault = 1;
    do_run(8'd2, 8'd3, 1'b0, 8'd1, 8'd3);
    fault = 2;
    do_run(8'd2, 8'd3, 1'b0, 8'd6, 8'd0);
    fault = 0;

    // Abort mid-run after vector 2 is on the outputs.
    seed_a = 8'd2; seed_b = 8'd3; start = 1'b1;
    push_run(cyc + 1, 8'd2, 8'd3, 1'b0, 8'd0, 8'd0, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 areset = 1'b1;
    #1;
    chk("abort_a", a, 0);
    chk("abort_b", b, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_first_err", first_err_idx, 8'hFF);
    @(negedge clk);
    areset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_q_empty", vec_q.size(), 0);
    do_run(8'd7, 8'd9, 1'b1, 8'd0, 8'hFF);

    // Start held for 12 cycles: one run, then a second accepted 9 edges after the first.
    seed_a = 8'd2; seed_b = 8'd3; start = 1'b1;
    t0 = cyc + 1;
    push_run(t0, 8'd2, 8'd3, 1'b1, 8'd0, 8'hFF, 6);
    push_run(t0 + 9, 8'd2, 8'd3, 1'b1, 8'd0, 8'hFF, 6);
    repeat (12) @(negedge clk);
    start = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sum_stim_checker.md
SUM_STIM_CHECKER -- requirements
Module: sum_stim_checker

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the operand and result width.
REQ-002 The block SHALL have parameter LAT, default 1, meaning the adder latency in clock edges (≥1); the registered adder has LAT=1.
REQ-003 The block SHALL have parameter N_VEC, default 6, meaning the vectors per run (legal range 1..254).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 areset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 seed_a  input  W  first A operand, captured on the start-accepting edge.
REQ-008 seed_b  input  W  first B operand, captured on the start-accepting edge.
REQ-009 a  output  W  operand A driven to the adder under test.
REQ-010 b  output  W  operand B driven to the adder under test.
REQ-011 c  input  W  result returned by the adder under test.
REQ-012 busy  output  1  high in DRIVE and DRAIN.
REQ-013 done  output  1  one-cycle pulse at the end of a run.
REQ-014 pass  output  1  high when the last completed run had zero mismatches; holds until the next start is accepted.
REQ-015 err_cnt  output  8  mismatch count of the current/last run, saturating at 255.
REQ-016 first_err_idx  output  8  index of the first mismatching vector; 0xFF if none.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE, DRAIN, DONE; transitions: IDLE->DRIVE on start=1; DRIVE->DRAIN after N_VEC drive cycles; DRAIN->DONE after the last compare; DONE->IDLE after one cycle.
REQ-018 Start-accepting edge T0: state becomes DRIVE, a=seed_a, b=seed_b (vector 0); err_cnt cleared, first_err_idx=0xFF, pass=0.
REQ-019 Vector k (0..N_VEC-1) SHALL be driven after edge T0+k: a_k = seed_a+k, b_k = seed_b+2k, both mod 2^W.
REQ-020 Expected c_k = (a_k+b_k) mod 2^W; carry discarded.
REQ-021 c for vector k SHALL be compared on edge T0+k+LAT+1, using an expected-value delay line of depth LAT+1 with a valid bit per slot.
REQ-022 Mismatch: any bit difference; in simulation X/Z on c counts as mismatch; err_cnt +1 (saturate 255); first_err_idx captures k only if still 0xFF.
REQ-023 a and b SHALL be 0 in IDLE, DRAIN and DONE.
REQ-024 The final compare is at edge T0+N_VEC+LAT; at that same edge state->DONE, done=1, pass=(err_cnt==0 including that compare).
REQ-025 start while busy or in DONE SHALL be ignored; start in IDLE the cycle after DONE is accepted.
REQ-026 busy=1 from after edge T0 until the DRAIN->DONE edge.

Reset
REQ-027 areset=1 SHALL immediately set state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0xFF, and clear all delay-line valid bits.
REQ-028 Reset mid-run SHALL abort it with no done pulse; the next accepted start SHALL restart from vector 0.

Verification (W=8, LAT=1, N_VEC=6, correct 1-cycle registered adder unless stated)
REQ-029 seed_a=2, seed_b=3, start at T0 -> a/b = (2,3),(3,5),(4,7),(5,9),(6,11),(7,13); expected c 5,8,11,14,17,20; done at T0+7; pass=1, err_cnt=0, first_err_idx=0xFF.
REQ-030 seed_a=0xFE, seed_b=0x01 -> vectors (FE,01),(FF,03),(00,05); expected 0xFF,0x02,0x05 (wrap); pass=1.
REQ-031 Adder returns sum+1 for vector 3 only -> err_cnt=1, first_err_idx=3, pass=0, done at T0+7.
REQ-032 Adder with 2-cycle latency while LAT=1 -> every compare fails; err_cnt=6, first_err_idx=0, pass=0.
REQ-033 areset pulsed after vector 2 is driven -> a=b=0 and busy=0 immediately; no done; a new start gives vector 0 = seeds.
REQ-034 start held high for 12 cycles from T0 -> exactly one run, one done pulse at T0+7; second run accepted on the edge after DONE exits to IDLE.
